// File: rtl/mac_feed_16.sv
// mac_feed_16: feeds a run of operand pairs into a 16x16 MAC and reports that run's dot product.
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   start, len         run request and its pair count, sampled in IDLE
//   in_valid/in_ready  operand handshake; in_a/in_b are the pair
//   dataa, datab       registered operands to the MAC
//   clk_en             registered MAC accumulate enable
//   mac_acc            MAC accumulator readback
//   busy, done, result not-idle flag, completion pulse, run dot product
module mac_feed_16 #(
    parameter int LEN_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      dataa,
    output logic [15:0]      datab,
    output logic             clk_en,
    input  logic [63:0]      mac_acc,
    output logic             busy,
    output logic             done,
    output logic [63:0]      result
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, CAPT} state_t;
    state_t           state;
    logic [63:0]      base;
    logic [LEN_W-1:0] remaining;
    assign in_ready = state == RUN;
    assign busy     = state != IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dataa     <= '0;
            datab     <= '0;
            clk_en    <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            base      <= '0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    clk_en <= 1'b0;
                    if (start && len != '0) begin
                        base      <= mac_acc;
                        remaining <= len;
                        state     <= RUN;
                    end else if (start) begin
                        result <= '0;
                        done   <= 1'b1;
                    end
                end
                RUN: begin
                    clk_en <= in_valid;
                    if (in_valid) begin
                        dataa     <= in_a;
                        datab     <= in_b;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= DRAIN;
                    end
                end
                // final pair is accumulated by the MAC at the edge leaving DRAIN
                DRAIN: begin
                    clk_en <= 1'b0;
                    state  <= CAPT;
                end
                // modular difference makes accumulator wrap-around harmless
                default: begin
                    result <= mac_acc - base;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule
